// File: rtl/button_pulse_conditioner.sv
// button_pulse_conditioner: synchronise and debounce the up/down buttons into single-cycle step pulses with mutual lockout.
// Define AUTO_REPEAT_EN to add hold-to-repeat pulses (HOLD -> REPEAT); otherwise one pulse per press.
module button_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic up_pulse,
  output logic down_pulse,
  output logic up_level,
  output logic down_level
);
`ifdef AUTO_REPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD, LOCKED, REPEAT} state_e;
`else
  typedef enum logic [1:0] {IDLE, HOLD, LOCKED} state_e;
`endif
  logic [1:0] raw, s1_q, s2_q, lvl_nxt, lvl, pls;
  assign raw = {btn_down_raw, btn_up_raw};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  for (genvar b = 0; b < 2; b++) begin : g_btn
    localparam int O = 1 - b;
    state_e st_q;
    logic [CNT_W-1:0] db_q, db_inc;
    logic lvl_q, lvl_d, pulse_q, rise, fall, oth;
    assign db_inc = &db_q ? db_q : db_q + CNT_W'(1);
    // the level flips on the same edge the counter would reach the threshold
    assign lvl_d = (s2_q[b] != lvl_q && db_inc == CNT_W'(DEBOUNCE_CYCLES)) ? ~lvl_q : lvl_q;
    assign rise = lvl_d & ~lvl_q;
    assign fall = ~lvl_d & lvl_q;
    // looking at the other button's next level makes same-edge rises lock both sides
    assign oth = lvl_nxt[O];
    assign lvl_nxt[b] = lvl_d;
    assign lvl[b] = lvl_q;
    assign pls[b] = pulse_q;
`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] rp_q, rp_inc;
    assign rp_inc = &rp_q ? rp_q : rp_q + CNT_W'(1);
`endif
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        st_q <= IDLE;
        db_q <= '0;
        lvl_q <= 1'b0;
        pulse_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
        rp_q <= '0;
`endif
      end else begin
        pulse_q <= 1'b0;
        lvl_q <= lvl_d;
        db_q <= (s2_q[b] == lvl_q || rise || fall) ? '0 : db_inc;
        if (fall) st_q <= IDLE;
        else
          case (st_q)
            IDLE: if (rise) begin
              st_q <= oth ? LOCKED : HOLD;
              pulse_q <= ~oth;
`ifdef AUTO_REPEAT_EN
              rp_q <= '0;
`endif
            end
`ifdef AUTO_REPEAT_EN
            HOLD:
              if (oth) st_q <= LOCKED;
              else if (rp_inc == CNT_W'(REPEAT_DELAY)) begin
                pulse_q <= 1'b1;
                st_q <= REPEAT;
                rp_q <= '0;
              end else rp_q <= rp_inc;
            REPEAT:
              if (oth) st_q <= LOCKED;
              else if (rp_inc == CNT_W'(REPEAT_PERIOD)) begin
                pulse_q <= 1'b1;
                rp_q <= '0;
              end else rp_q <= rp_inc;
`else
            HOLD: if (oth) st_q <= LOCKED;
`endif
            default: st_q <= st_q;
          endcase
      end
  end
  assign up_pulse = pls[0];
  assign down_pulse = pls[1];
  assign up_level = lvl[0];
  assign down_level = lvl[1];
endmodule

// File: tb/tb_button_pulse_conditioner.sv
// tb_button_pulse_conditioner: directed checks of debounce, press/repeat pulses, lockout and reset recovery.
module tb_button_pulse_conditioner;
  logic clk = 1'b0, rst_n = 1'b0, btn_up_raw = 1'b0, btn_down_raw = 1'b0;
  logic up_pulse, down_pulse, up_level, down_level;
  int checks = 0, errors = 0;
  int up_n = 0, dn_n = 0, both_n = 0;
  int u0, d0;
  logic exp_p;

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw),
    .up_pulse(up_pulse), .down_pulse(down_pulse), .up_level(up_level), .down_level(down_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (up_pulse) up_n++;
    if (down_pulse) dn_n++;
    if (up_pulse && down_pulse) both_n++;
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, " up_pulse"}, up_pulse, 1'b0);
    chk({tag, " down_pulse"}, down_pulse, 1'b0);
    chk({tag, " up_level"}, up_level, 1'b0);
    chk({tag, " down_level"}, down_level, 1'b0);
  endtask

  initial begin
    // reset, then up held from edge 10 (edges counted from reset release)
    go(3);
    chk_all0("in reset");
    rst_n = 1'b1;
    go(1);
    chk_all0("edge1");
    go(8);
    btn_up_raw = 1'b1;
    go(5);
    chk("e14 up_level", up_level, 1'b0);
    chk("e14 up_pulse", up_pulse, 1'b0);
    go(1);
    chk("e15 up_level", up_level, 1'b1);
    chk("e15 up_pulse", up_pulse, 1'b1);
    go(1);
    chk("e16 up_pulse", up_pulse, 1'b0);
    // raw drops at edge 47; level falls at 52 where a repeat pulse would be due
    for (int e = 17; e <= 58; e++) begin
      go(1);
      if (e == 46) btn_up_raw = 1'b0;
`ifdef AUTO_REPEAT_EN
      exp_p = (e >= 25 && e <= 49 && (e - 25) % 3 == 0);
`else
      exp_p = 1'b0;
`endif
      chk($sformatf("hold e%0d up_pulse", e), up_pulse, exp_p);
      chk($sformatf("hold e%0d up_level", e), up_level, e < 52);
    end
    // down glitches of 3 cycles never qualify
    d0 = dn_n;
    for (int r = 0; r < 5; r++) begin
      btn_down_raw = 1'b1;
      go(3);
      btn_down_raw = 1'b0;
      go(3);
      chk($sformatf("glitch r%0d down_level", r), down_level, 1'b0);
    end
    go(4);
    chk("glitch down_level", down_level, 1'b0);
    chk_int("glitch down pulses", dn_n - d0, 0);
    // up held, down pressed 5 cycles later
    u0 = up_n;
    d0 = dn_n;
    btn_up_raw = 1'b1;
    go(5);
    btn_down_raw = 1'b1;
    go(1);
    chk("lock up_pulse", up_pulse, 1'b1);
    go(5);
    chk("lock down_level", down_level, 1'b1);
    chk("lock down_pulse", down_pulse, 1'b0);
    go(10);
    chk_int("lock up pulses", up_n - u0, 1);
    chk_int("lock down pulses", dn_n - d0, 0);
    btn_down_raw = 1'b0;
    go(20);
    chk("lock down released", down_level, 1'b0);
    chk("lock up still held", up_level, 1'b1);
    chk_int("lock no resume", up_n - u0, 1);
    btn_up_raw = 1'b0;
    go(8);
    chk("lock up released", up_level, 1'b0);
    btn_up_raw = 1'b1;
    go(6);
    chk("repress up_pulse", up_pulse, 1'b1);
    go(1);
    chk_int("repress up pulses", up_n - u0, 2);
    btn_up_raw = 1'b0;
    go(8);
    // simultaneous press locks both
    u0 = up_n;
    d0 = dn_n;
    btn_up_raw = 1'b1;
    btn_down_raw = 1'b1;
    go(5);
    chk("both e+4 up_level", up_level, 1'b0);
    go(1);
    chk("both up_level", up_level, 1'b1);
    chk("both down_level", down_level, 1'b1);
    go(15);
    chk_int("both up pulses", up_n - u0, 0);
    chk_int("both down pulses", dn_n - d0, 0);
    btn_up_raw = 1'b0;
    btn_down_raw = 1'b0;
    go(8);
    // reset while up is held in its repeat phase
    btn_up_raw = 1'b1;
    go(6);
    chk("pre-reset up_pulse", up_pulse, 1'b1);
    go(14);
    chk("pre-reset up_level", up_level, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all0("async reset");
    go(2);
    rst_n = 1'b1;
    go(5);
    chk("post-reset e5 up_level", up_level, 1'b0);
    chk("post-reset e5 up_pulse", up_pulse, 1'b0);
    go(1);
    chk("post-reset e6 up_level", up_level, 1'b1);
    chk("post-reset e6 up_pulse", up_pulse, 1'b1);
    go(1);
    chk("post-reset e7 up_pulse", up_pulse, 1'b0);
    btn_up_raw = 1'b0;
    go(8);
    chk_int("no pulse overlap", both_n, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
